// File: rtl/cfg_arb_pkg.sv
// Shared types and helpers for the configuration-register write arbiter.
// The FSM state type is only used when CFG_ARB_LOCK_EN is defined.
package cfg_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Pointer width for n requesters, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ARB_NUM_REQ_DEFAULT = 4;
  localparam int ARB_PTR_WIDTH       = ptr_width(ARB_NUM_REQ_DEFAULT);

endpackage

// File: rtl/cfg_reg_write_arbiter_rr_priority_select.sv
// Combinational round-robin selector: starting at ptr, the first set request
// (wrapping modulo NUM_REQ) wins. Produces a one-hot grant and its index.
module rr_priority_select
  import cfg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [PW:0] cand;

  // Scan offsets from farthest to nearest so the nearest request is kept last.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW + 1)'(k);
      if (cand >= (PW + 1)'(NUM_REQ)) cand = cand - (PW + 1)'(NUM_REQ);
      if (req[cand[PW-1:0]]) begin
        grant                = '0;
        grant[cand[PW-1:0]]  = 1'b1;
        idx                  = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/cfg_reg_write_arbiter.sv
// Round-robin write arbiter in front of the configuration register bank.
// Each accepted beat becomes a registered one-hot enable plus write data.
// Optional feature macro: CFG_ARB_LOCK_EN adds req_last and burst locking.
module cfg_reg_write_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
`ifdef CFG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             req_last,
`endif
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REGS-1:0]            reg_enable,
  output logic [DATA_WIDTH-1:0]          reg_wdata,
  output logic                           addr_err
);

  localparam int PW = ptr_width(NUM_REQ);

  logic [PW-1:0]         ptr_reg, ptr_next, ptr_after, gnt_idx;
  logic [NUM_REQ-1:0]    eligible, gnt;
  logic                  fire;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_select (
    .req   (eligible),
    .ptr   (ptr_reg),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign req_ready    = gnt;
  assign fire         = |gnt;
  assign sel_addr     = addr_arr[gnt_idx];
  assign sel_data     = data_arr[gnt_idx];
  // Extra bit lets NUM_REGS == 2**ADDR_WIDTH compare correctly.
  assign sel_in_range = ({1'b0, sel_addr} < (ADDR_WIDTH + 1)'(NUM_REGS));
  assign ptr_after    = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);

`ifdef CFG_ARB_LOCK_EN
  arb_state_e         state_reg, state_next;
  logic [PW-1:0]      owner_reg, owner_next;
  logic [NUM_REQ-1:0] owner_mask;
  logic               sel_last;

  assign owner_mask = NUM_REQ'(1) << owner_reg;
  assign sel_last   = req_last[gnt_idx];
  // While locked only the burst owner may be granted, idle or not.
  assign eligible   = (state_reg == ARB_LOCKED) ? (req_valid & owner_mask) : req_valid;

  // Burst FSM: a non-last beat locks onto its requester; ptr moves only on last.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    if (fire) begin
      case (state_reg)
        ARB_IDLE: begin
          if (sel_last) begin
            ptr_next = ptr_after;
          end else begin
            state_next = ARB_LOCKED;
            owner_next = gnt_idx;
          end
        end
        ARB_LOCKED: begin
          if (sel_last) begin
            state_next = ARB_IDLE;
            ptr_next   = ptr_after;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  // FSM state and lock owner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
    end
  end
`else
  assign eligible = req_valid;
  assign ptr_next = fire ? ptr_after : ptr_reg;
`endif

  // Round-robin pointer: next-highest priority after the last completed grant.
  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

  // Write issue: one-hot enable pulse per in-range beat; sticky error otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_enable <= '0;
      reg_wdata  <= '0;
      addr_err   <= 1'b0;
    end else begin
      reg_enable <= '0;
      if (fire) begin
        if (sel_in_range) begin
          reg_enable <= NUM_REGS'(1) << sel_addr;
          reg_wdata  <= sel_data;
        end else begin
          addr_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_reg_write_arbiter.sv
// Directed bench for cfg_reg_write_arbiter (NUM_REQ=4, NUM_REGS=6).
// A vector table covers grant order, pointer memory, range errors and
// same-register writes; hand sequences cover reset and burst locking.
module tb_cfg_reg_write_arbiter;

  localparam int NR = 4;
  localparam int NG = 6;
  localparam int AW = 3;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
`ifdef CFG_ARB_LOCK_EN
  logic [NR-1:0]    req_last;
`endif
  logic [NR-1:0]    req_ready;
  logic [NG-1:0]    reg_enable;
  logic [DW-1:0]    reg_wdata;
  logic             addr_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cfg_reg_write_arbiter #(
    .NUM_REQ    (NR),
    .NUM_REGS   (NG),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
`ifdef CFG_ARB_LOCK_EN
    .req_last   (req_last),
`endif
    .req_ready  (req_ready),
    .reg_enable (reg_enable),
    .reg_wdata  (reg_wdata),
    .addr_err   (addr_err)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] addr;
    logic [3:0]  ready;
    logic [5:0]  en;
    logic [31:0] wdata;
    logic        err;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic [3:0] valid, input logic [11:0] addr,
                              input logic [3:0] ready, input logic [5:0] en,
                              input logic [31:0] wdata, input logic err);
    vec_t v;
    v.valid = valid; v.addr = addr; v.ready = ready;
    v.en = en; v.wdata = wdata; v.err = err;
    return v;
  endfunction

  function automatic logic [11:0] pk(input logic [2:0] a3, input logic [2:0] a2,
                                     input logic [2:0] a1, input logic [2:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  // Data word for requester i in transaction v: 0xC0DE_vv_ii.
  function automatic logic [DW-1:0] dat(input int v, input int i);
    return {16'hC0DE, 8'(v), 8'(i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, input logic [11:0] addr, input int v);
    req_valid = valid;
    req_addr  = addr;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat(v, i);
  endtask

  // One handshake cycle: check ready now, then enable the cycle after the edge.
  task automatic step(input string name, input logic [3:0] valid, input logic [11:0] addr,
                      input int v, input logic [3:0] exp_ready, input logic [5:0] exp_en);
    drive(valid, addr, v);
    #1;
    check({name, " ready"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    check({name, " enable"}, 32'(reg_enable), 32'(exp_en));
    $display("[TB] %s: valid=%b ready=%b enable=%b wdata=%h err=%b",
             name, valid, req_ready, reg_enable, reg_wdata, addr_err);
  endtask

  initial begin
    // Fairness: all four valid, grant order 0,1,2,3,0,1,2,3 with a pulse every cycle.
    for (int v = 0; v < 8; v++) begin
      logic [5:0] ens [4];
      ens[0] = 6'h01; ens[1] = 6'h02; ens[2] = 6'h04; ens[3] = 6'h10;
      vt[v] = mk(4'hF, pk(3'd4, 3'd2, 3'd1, 3'd0), 4'(1 << (v % 4)), ens[v % 4],
                 {16'hC0DE, 8'(v), 8'(v % 4)}, 1'b0);
    end
    // Single write from req0 to reg 3 (ptr back at 0), then idle: data holds.
    vt[8]  = mk(4'h1, pk(3'd0, 3'd0, 3'd0, 3'd3), 4'h1, 6'h08, 32'hC0DE_0800, 1'b0);
    vt[9]  = mk(4'h0, pk(3'd0, 3'd0, 3'd0, 3'd0), 4'h0, 6'h00, 32'hC0DE_0800, 1'b0);
    // Pointer memory: grant req2, then req1+req3 together -> req3, then req1.
    vt[10] = mk(4'h4, pk(3'd0, 3'd5, 3'd0, 3'd0), 4'h4, 6'h20, 32'hC0DE_0A02, 1'b0);
    vt[11] = mk(4'hA, pk(3'd2, 3'd0, 3'd1, 3'd0), 4'h8, 6'h04, 32'hC0DE_0B03, 1'b0);
    vt[12] = mk(4'h2, pk(3'd0, 3'd0, 3'd1, 3'd0), 4'h2, 6'h02, 32'hC0DE_0C01, 1'b0);
    // Out of range (7, then the boundary 6): accepted, no enable, sticky error.
    vt[13] = mk(4'h1, pk(3'd0, 3'd0, 3'd0, 3'd7), 4'h1, 6'h00, 32'hC0DE_0C01, 1'b1);
    vt[14] = mk(4'h1, pk(3'd0, 3'd0, 3'd0, 3'd6), 4'h1, 6'h00, 32'hC0DE_0C01, 1'b1);
    // Same register from req1 then req0 in consecutive cycles, both issued.
    vt[15] = mk(4'h3, pk(3'd0, 3'd0, 3'd5, 3'd5), 4'h2, 6'h20, 32'hC0DE_0F01, 1'b1);
    vt[16] = mk(4'h1, pk(3'd0, 3'd0, 3'd0, 3'd5), 4'h1, 6'h20, 32'hC0DE_1000, 1'b1);
    vt[17] = mk(4'h0, pk(3'd0, 3'd0, 3'd0, 3'd0), 4'h0, 6'h00, 32'hC0DE_1000, 1'b1);

    reset = 1'b1;
    drive(4'h0, 12'h000, 0);
`ifdef CFG_ARB_LOCK_EN
    req_last = '1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset enable", 32'(reg_enable), 32'h0);
    check("reset wdata", reg_wdata, 32'h0);
    check("reset addr_err", 32'(addr_err), 32'h0);
    check("reset ready", 32'(req_ready), 32'h0);
    $display("[TB] reset: enable=%b wdata=%h err=%b", reg_enable, reg_wdata, addr_err);
    reset = 1'b0;

    for (int v = 0; v < 18; v++) begin
      drive(vt[v].valid, vt[v].addr, v);
      #1;
      check($sformatf("v%0d ready", v), 32'(req_ready), 32'(vt[v].ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d enable", v), 32'(reg_enable), 32'(vt[v].en));
      check($sformatf("v%0d wdata", v), reg_wdata, vt[v].wdata);
      check($sformatf("v%0d addr_err", v), 32'(addr_err), 32'(vt[v].err));
      $display("[TB] v%0d: valid=%b ready=%b enable=%b wdata=%h err=%b",
               v, vt[v].valid, req_ready, reg_enable, reg_wdata, addr_err);
    end

    // Reset with a write in flight wins over the handshake and clears the error.
    drive(4'hF, pk(3'd1, 3'd1, 3'd1, 3'd1), 20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst enable", 32'(reg_enable), 32'h0);
    check("rst wdata", reg_wdata, 32'h0);
    check("rst addr_err", 32'(addr_err), 32'h0);
    $display("[TB] reset in flight: enable=%b wdata=%h err=%b", reg_enable, reg_wdata, addr_err);
    reset = 1'b0;
    step("post-reset req0 first", 4'hF, pk(3'd1, 3'd1, 3'd1, 3'd1), 21, 4'h1, 6'h02);
    check("post-reset wdata", reg_wdata, 32'hC0DE_1500);

`ifdef CFG_ARB_LOCK_EN
    // ptr is 1 here. req1 bursts 3 beats while req0 stays valid.
    req_last = 4'b1101;
    step("lock beat1", 4'h3, pk(3'd0, 3'd0, 3'd2, 3'd3), 30, 4'h2, 6'h04);
    step("lock beat2", 4'h3, pk(3'd0, 3'd0, 3'd2, 3'd3), 31, 4'h2, 6'h04);
    step("lock owner idle", 4'h1, pk(3'd0, 3'd0, 3'd2, 3'd3), 32, 4'h0, 6'h00);
    req_last = 4'b1111;
    step("lock beat3 last", 4'h3, pk(3'd0, 3'd0, 3'd2, 3'd3), 33, 4'h2, 6'h04);
    // ptr must now be 2: req2 beats req0.
    step("ptr after burst", 4'h5, pk(3'd0, 3'd1, 3'd0, 3'd3), 34, 4'h4, 6'h02);
    // ptr is 3: req3 starts a burst, req0 is locked out, then reset mid-burst.
    req_last = 4'b0111;
    step("lock req3", 4'h8, pk(3'd4, 3'd0, 3'd0, 3'd0), 35, 4'h8, 6'h10);
    drive(4'h9, pk(3'd4, 3'd0, 3'd0, 3'd0), 36);
    #1;
    check("locked req0 blocked", 32'(req_ready), 32'h8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("lock rst enable", 32'(reg_enable), 32'h0);
    check("lock rst wdata", reg_wdata, 32'h0);
    check("lock rst addr_err", 32'(addr_err), 32'h0);
    reset = 1'b0;
    step("after lock reset", 4'hB, pk(3'd4, 3'd0, 3'd1, 3'd3), 37, 4'h1, 6'h08);
    req_last = 4'b1111;
`endif

    drive(4'h0, 12'h000, 0);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_reg_write_arbiter.md
# cfg_reg_write_arbiter

Round-robin arbiter that shares one bank of enabled configuration registers (synchronous-reset, write-enable registers) among several requesters: instruction decoder, host CSR path, loop controller. Each accepted write is turned into a one-hot write enable plus registered write data that drive the register bank. The block sits between the requesters and the register bank in the accelerator control path. It guarantees at most one register write per cycle.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, registers in the bank
- ADDR_WIDTH, 3, register address width; 2^ADDR_WIDTH >= NUM_REGS
- DATA_WIDTH, 32, register width
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed target addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
- req_last  input  NUM_REQ  last beat of a locked burst; present only with CFG_ARB_LOCK_EN
- req_ready  output  NUM_REQ  grant; a beat transfers when valid & ready
- reg_enable  output  NUM_REGS  one-hot write enable to the register bank
- reg_wdata  output  DATA_WIDTH  write data to the register bank
- addr_err  output  1  sticky: an out-of-range address was accepted

## Operation
- Grant:
  - req_ready is combinational from req_valid, the pointer and the state.
  - At most one bit of req_ready is high. It is only high when the matching req_valid is high.
- Round-robin:
  - Pointer ptr names the highest-priority requester. Search order is ptr, ptr+1, … wrapping modulo NUM_REQ.
  - After a completed grant to requester g, ptr becomes (g+1) mod NUM_REQ.
  - ptr does not change in cycles with no transfer.
- Write issue:
  - An accepted beat with addr < NUM_REGS registers reg_enable = 1<<addr and reg_wdata = data.
  - With no transfer, or an out-of-range address, reg_enable registers to 0 and reg_wdata holds its value.
- Out-of-range address (addr >= NUM_REGS):
  - The beat is still accepted, so the requester is not stalled.
  - The write is dropped and addr_err sets.
  - addr_err clears only on reset.
- Reset values: reg_enable=0, reg_wdata=0, addr_err=0, ptr=0, state IDLE.
- req_ready follows from the state, so it is 0 while all req_valid are 0.
- Reset has priority over every other event in the same cycle.

## Timing
- Handshake at edge N: reg_enable/reg_wdata are valid during cycle N+1. The register bank captures the value at edge N+1.
- Latency request-to-register-update: 2 edges.
- Throughput: one write per cycle, sustained, back-to-back across requesters.
- A requester holds addr/data stable while valid is high and ready is low. Dropping valid without a handshake is legal and has no effect.
- Simultaneous requests: the winner is decided purely by ptr. A new request that arrives in the same cycle as a grant elsewhere waits at least one cycle.
- Two requesters targeting the same register in consecutive cycles: both writes are issued, in grant order. The last one wins.

## Configuration
- CFG_ARB_LOCK_EN defined:
  - The req_last port exists, and a two-state FSM is active.
  - IDLE: normal round-robin. A granted beat with last=0 moves the FSM to LOCKED(g).
  - LOCKED(g): only requester g can be granted; others see ready=0 even if g is idle.
  - A beat from g with last=1 returns the FSM to IDLE and advances ptr. ptr is frozen while LOCKED.
  - Reset in LOCKED returns the FSM to IDLE.
- CFG_ARB_LOCK_EN undefined:
  - No req_last port and no FSM.
  - Every beat is arbitrated independently, and ptr advances on every transfer.

## Structure
- Shared package cfg_arb_pkg holds the FSM state enum (ARB_IDLE, ARB_LOCKED) and the localparam for the pointer width, clog2(NUM_REQ).
- One sub-module, rr_priority_select: combinational. Inputs are the request vector and ptr; outputs are a one-hot grant and the binary index.
- The top level holds ptr, the lock owner, the FSM, output registers and the error flag.

## Test plan
- Single write:
  - Stimulus: after reset, req0 writes addr 3, data 0xDEADBEEF.
  - Response: req_ready[0]=1 in the same cycle, reg_enable=0x08 and reg_wdata=0xDEADBEEF the next cycle, then reg_enable=0.
- Fairness:
  - Stimulus: all 4 requesters hold valid for 8 cycles.
  - Response: grant order is 0,1,2,3,0,1,2,3 and reg_enable pulses every cycle.
- Pointer memory:
  - Stimulus: grant req2, then req1 and req3 request together.
  - Response: req3 wins first, then req1.
- Out-of-range:
  - Stimulus: with NUM_REGS=6, write addr 7.
  - Response: handshake completes, reg_enable stays 0, addr_err=1 and holds until reset.
- Lock (with CFG_ARB_LOCK_EN):
  - Stimulus: req1 sends 3 beats, last on the third, while req0 is valid throughout.
  - Response: req0 is ready only after req1's third beat, and ptr=2 after the burst.
- Reset mid-operation:
  - Stimulus: assert reset during LOCKED with writes in flight.
  - Response: the next cycle shows reg_enable=0, reg_wdata=0, addr_err=0, IDLE, and req0 has priority.
